// File: rtl/tkg_arb_pkg.sv
// Shared definitions for the tkg_arbn N-way clocked mutex: FSM encoding,
// arbitration mode constants and the index-width helper.
package tkg_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_GRANT   = 2'd1;
    localparam arb_state_t ST_RELEASE = 2'd2;

    localparam int TKG_ARB_FIXED = 0;
    localparam int TKG_ARB_RR    = 1;

    localparam int HOLD_W = 16;

    // A channel index is never narrower than one bit, even for N = 2.
    function automatic int tkg_arb_idx_w(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/tkg_arbn_if.sv
// Request/grant bundle between N requesters and the tkg_arbn arbiter.
interface tkg_arbn_if
    import tkg_arb_pkg::*;
#(
    parameter int N = 4
);
    localparam int W = tkg_arb_idx_w(N);

    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         busy;
    logic         overrun;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  overrun
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output busy,
        output overrun
    );

endinterface

// File: rtl/tkg_arbn_pick.sv
// Combinational winner search: lowest index in fixed mode, or first asserted
// request at or above base (wrapping) in round-robin mode.
module tkg_arbn_pick
    import tkg_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = tkg_arb_idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] idx
);

    logic         found_s;
    logic [W-1:0] idx_s;
    logic [W-1:0] pos_s;

    // Scan channels in priority order and keep the first asserted one.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {W{1'b0}};
        pos_s   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (mode == 1'b1) begin
                pos_s = W'((int'(base) + i) % N);
            end else begin
                pos_s = W'(i);
            end
            if (!found_s && req[pos_s]) begin
                found_s = 1'b1;
                idx_s   = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign found = found_s;
    assign idx   = idx_s;

endmodule

// File: rtl/tkg_arbn.sv
// Clocked N-way mutex: IDLE -> GRANT -> RELEASE -> IDLE, one registered
// one-hot grant at a time, with a sticky hold-time overrun flag.
module tkg_arbn
    import tkg_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 255
) (
    input  logic   clk,
    input  logic   reset,
    tkg_arbn_if.slave arb
);

    localparam int               W        = tkg_arb_idx_w(N);
    localparam logic [W-1:0]     LAST_CH  = W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic             PICK_RR  = (MODE == TKG_ARB_RR) ? 1'b1 : 1'b0;
    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};

    arb_state_t        state_r,   state_s;
    logic [W-1:0]      owner_r,   owner_s;
    logic [HOLD_W-1:0] hold_r,    hold_s;
    logic [N-1:0]      gnt_r,     gnt_s;
    logic [W-1:0]      gnt_idx_r, gnt_idx_s;
    logic              busy_r,    busy_s;
    logic              overrun_r, overrun_s;

    logic [W-1:0]      base_s;
    logic              found_s;
    logic [W-1:0]      pick_idx_s;

    // owner_r doubles as last_owner: it keeps the previous winner through
    // RELEASE and IDLE, so the round-robin search starts just above it.
    always_comb begin
        if (owner_r == LAST_CH) begin
            base_s = {W{1'b0}};
        end else begin
            base_s = owner_r + W'(1);
        end
    end

    tkg_arbn_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (arb.req),
        .base  (base_s),
        .mode  (PICK_RR),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    // Next-state logic; hold_r counts GRANT cycles including the current one.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_GRANT;
                    owner_s = pick_idx_s;
                    hold_s  = 16'd1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (arb.req[owner_r]) begin
                    if (hold_r >= HOLD_MAX) begin
                        hold_s = hold_r;
                    end else begin
                        hold_s = hold_r + 16'd1;
                    end
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (state_s == ST_GRANT) begin
            gnt_s     = ONE_N << owner_s;
            gnt_idx_s = owner_s;
            busy_s    = 1'b1;
            overrun_s = overrun_r | (hold_s == HOLD_MAX);
        end else begin
            gnt_s     = {N{1'b0}};
            gnt_idx_s = {W{1'b0}};
            busy_s    = 1'b0;
            overrun_s = overrun_r;
        end
    end

    // State and output registers; reset clears grants without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            owner_r   <= LAST_CH;
            hold_r    <= 16'd0;
            gnt_r     <= {N{1'b0}};
            gnt_idx_r <= {W{1'b0}};
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            hold_r    <= hold_s;
            gnt_r     <= gnt_s;
            gnt_idx_r <= gnt_idx_s;
            busy_r    <= busy_s;
            overrun_r <= overrun_s;
        end
    end

    assign arb.gnt     = gnt_r;
    assign arb.gnt_idx = gnt_idx_r;
    assign arb.busy    = busy_r;
    assign arb.overrun = overrun_r;

endmodule

// File: tb/tb_tkg_arbn.sv
// Bench for tkg_arbn: a round-robin and a fixed-priority instance (N=4,
// MAX_HOLD=8) driven by directed steps, then random requests vs a reference model.
module tb_tkg_arbn;
    import tkg_arb_pkg::*;

    localparam int MH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tkg_arbn_if #(.N(4)) if_rr ();
    tkg_arbn_if #(.N(4)) if_fp ();

    tkg_arbn #(.N(4), .MODE(TKG_ARB_RR), .MAX_HOLD(MH)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .arb   (if_rr)
    );

    tkg_arbn #(.N(4), .MODE(TKG_ARB_FIXED), .MAX_HOLD(MH)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .arb   (if_fp)
    );

    int errors = 0;
    int checks = 0;

    // Reference model, index 0 = round-robin instance, 1 = fixed priority.
    int         m_owner [2];   // current grantee, -1 when none
    int         m_cool  [2];   // 1 during the mandatory dead cycle after release
    int         m_last  [2];
    int         m_held  [2];   // cycles granted so far to the current owner
    bit         m_ovr   [2];
    logic [3:0] m_redge [2];   // requests seen at the latest edge

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit bit_at(input logic [3:0] v, input int p);
        return v[p[1:0]];
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (bit_at(v, i)) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_cool[k]  = 0;
            m_last[k]  = 3;
            m_held[k]  = 0;
            m_ovr[k]   = 1'b0;
            m_redge[k] = 4'b0000;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int w;
        int c;
        m_redge[k] = r;
        if (m_owner[k] >= 0) begin
            if (bit_at(r, m_owner[k])) begin
                if (m_held[k] < MH) m_held[k]++;
                if (m_held[k] >= MH) m_ovr[k] = 1'b1;
            end else begin
                m_owner[k] = -1;
                m_cool[k]  = 1;
            end
        end else if (m_cool[k] != 0) begin
            m_cool[k] = 0;
        end else if (r != 4'b0000) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                c = (k == 1) ? i : (m_last[k] + 1 + i) % 4;
                if (w < 0 && bit_at(r, c)) w = c;
            end
            m_owner[k] = w;
            m_last[k]  = w;
            m_held[k]  = 1;
            if (m_held[k] >= MH) m_ovr[k] = 1'b1;
        end
    endtask

    task automatic check_inst(input int k, input string nm);
        logic [3:0] g;
        logic [3:0] eg;
        logic [1:0] gi;
        logic       b;
        logic       o;
        if (k == 0) begin
            g = if_rr.gnt; gi = if_rr.gnt_idx; b = if_rr.busy; o = if_rr.overrun;
        end else begin
            g = if_fp.gnt; gi = if_fp.gnt_idx; b = if_fp.busy; o = if_fp.overrun;
        end
        eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
        chk({nm, ".gnt"},     32'(g),  32'(eg));
        chk({nm, ".gnt_idx"}, 32'(gi), (m_owner[k] >= 0) ? m_owner[k] : 0);
        chk({nm, ".busy"},    32'(b),  (m_owner[k] >= 0) ? 1 : 0);
        chk({nm, ".overrun"}, 32'(o),  32'(m_ovr[k]));
        chk({nm, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        chk({nm, ".gnt_wo_req"}, 32'(g & ~m_redge[k]), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, if_rr.req);
        model_step(1, if_fp.req);
        #1;
        check_inst(0, "rr");
        check_inst(1, "fp");
    endtask

    initial begin
        int order [5];
        int gap   [5];
        int ng;
        int dead;
        int gcount;

        reset = 1'b1;
        if_rr.req = 4'b0000;
        if_fp.req = 4'b0000;
        model_reset();
        #12;
        check_inst(0, "rst_rr");
        check_inst(1, "rst_fp");
        reset = 1'b0;

        // Round-robin rotation with each owner dropping after one grant cycle.
        for (int i = 0; i < 5; i++) begin
            order[i] = -1;
            gap[i]   = -1;
        end
        ng = 0;
        dead = 0;
        if_rr.req = 4'b1111;
        for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
            tick();
            if (if_rr.gnt != 4'b0000) begin
                order[ng] = oh_idx(if_rr.gnt);
                gap[ng]   = dead;
                ng++;
                dead = 0;
                if_rr.req = (ng < 5) ? (4'b1111 & ~if_rr.gnt) : 4'b0000;
            end else begin
                dead++;
                if_rr.req = 4'b1111;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", order[i], i % 4);
            if (i > 0) chk("rr_dead_cycles", gap[i], 2);
        end
        if_rr.req = 4'b0000;
        tick();
        tick();

        // Wrap-around: owner 3 last, then channels 0 and 1 request.
        if_rr.req = 4'b1000;
        tick();
        chk("wrap_pre_gnt", 32'(if_rr.gnt), 32'(4'b1000));
        if_rr.req = 4'b0000;
        tick();
        tick();
        if_rr.req = 4'b0011;
        tick();
        chk("wrap_gnt", 32'(if_rr.gnt), 32'(4'b0001));
        chk("wrap_gnt_idx", 32'(if_rr.gnt_idx), 32'd0);
        if_rr.req = 4'b0000;
        tick();
        tick();

        // Fixed priority: channel 1 beats 3, then 3 after two dead cycles.
        if_fp.req = 4'b1010;
        tick();
        chk("fp_first", 32'(if_fp.gnt), 32'(4'b0010));
        if_fp.req = 4'b1000;
        tick();
        chk("fp_release", 32'(if_fp.gnt), 32'(4'b0000));
        tick();
        chk("fp_idle", 32'(if_fp.gnt), 32'(4'b0000));
        tick();
        chk("fp_second", 32'(if_fp.gnt), 32'(4'b1000));
        if_fp.req = 4'b0000;
        tick();
        tick();

        // Hold channel 2 for 20 cycles: overrun from the 8th grant cycle on.
        gcount = 0;
        if_rr.req = 4'b0100;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (if_rr.gnt != 4'b0000) gcount++;
            chk("hold_gnt", 32'(if_rr.gnt), 32'(4'b0100));
            chk("hold_overrun", 32'(if_rr.overrun), (gcount >= MH) ? 1 : 0);
        end
        if_rr.req = 4'b0000;
        tick();
        tick();
        tick();
        chk("overrun_sticky", 32'(if_rr.overrun), 32'd1);

        // Asynchronous reset in the middle of a grant.
        if_rr.req = 4'b0100;
        tick();
        chk("pre_reset_gnt", 32'(if_rr.gnt), 32'(4'b0100));
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_gnt", 32'(if_rr.gnt), 32'(4'b0000));
        chk("async_busy", 32'(if_rr.busy), 32'd0);
        chk("async_overrun", 32'(if_rr.overrun), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("regrant", 32'(if_rr.gnt), 32'(4'b0100));
        if_rr.req = 4'b0000;
        tick();
        tick();

        // Random requests on both instances, each bit toggling with p = 1/4.
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if_rr.req = if_rr.req ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if_fp.req = if_fp.req ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
